// File: rtl/hc595_rx_monitor_pkg.sv
// Shared frame format for the 74HC595 segment-display link.
// Driver and receiver both import this so bit order cannot drift.
package hc595_rx_monitor_pkg;

  localparam int unsigned SEG_W      = 8;
  localparam int unsigned SEL_W      = 6;
  localparam int unsigned FRAME_BITS = SEG_W + SEL_W;
  localparam int unsigned CNT_W      = 5;
  localparam int unsigned CNT_MAX    = (1 << CNT_W) - 1;
  localparam int unsigned SR_IDX_W   = $clog2(FRAME_BITS);
  localparam int unsigned SEG_IDX_W  = $clog2(SEG_W);
  localparam int unsigned SEL_IDX_W  = $clog2(SEL_W);

  // Position of each word's bit 0 after a complete frame; later bits sit at lower indices.
  localparam int unsigned SEG0_IDX     = FRAME_BITS - 1;
  localparam int unsigned SEG_LAST_IDX = FRAME_BITS - SEG_W;
  localparam int unsigned SEL0_IDX     = SEL_W - 1;
  localparam int unsigned SEL_LAST_IDX = 0;

  typedef enum logic {
    ST_IDLE,
    ST_SHIFTING
  } rx_state_e;

  typedef struct packed {
    logic [SEG_W-1:0] seg;
    logic [SEL_W-1:0] sel;
  } frame_word_t;

  // First bit shifted ends up in the MSB, so each word is bit-reversed out of sr.
  function automatic frame_word_t unpack_frame(input logic [FRAME_BITS-1:0] sr);
    frame_word_t w;
    for (int i = 0; i < int'(SEG_W); i++) begin
      w.seg[SEG_IDX_W'(i)] = sr[SR_IDX_W'(SEG0_IDX - 32'(i))];
    end
    for (int j = 0; j < int'(SEL_W); j++) begin
      w.sel[SEL_IDX_W'(j)] = sr[SR_IDX_W'(SEL0_IDX - 32'(j))];
    end
    return w;
  endfunction

endpackage

// File: rtl/hc595_rx_monitor_sync_edge_det.sv
// Multi-flop synchroniser for one asynchronous bit, plus a rising-edge strobe.
module hc595_rx_monitor_sync_edge_det #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise_c
);

  logic [STAGES-1:0] chain;
  logic              q_d;

  // Sync chain plus one extra copy of the last stage for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= {STAGES{RST_VAL}};
      q_d   <= RST_VAL;
    end else begin
      chain <= {chain[STAGES-2:0], d};
      q_d   <= chain[STAGES-1];
    end
  end

  assign q      = chain[STAGES-1];
  assign rise_c = chain[STAGES-1] & ~q_d;

endmodule

// File: rtl/hc595_rx_monitor.sv
// Receive-side model of two cascaded 74HC595s: rebuilds the segment and
// digit-select words from ds/shcp/stcp/oe and flags frames with a bad shift count.
module hc595_rx_monitor
  import hc595_rx_monitor_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             ds,
  input  logic             shcp,
  input  logic             stcp,
  input  logic             oe,
  output logic [SEG_W-1:0] seg_out,
  output logic [SEL_W-1:0] sel_out,
  output logic             blank,
  output logic             frame_vld,
  output logic             frame_err,
  output logic [CNT_W-1:0] shift_cnt
);

  logic ds_sync, shcp_sync, stcp_sync, oe_sync;
  logic shcp_rise_c, stcp_rise_c;
  logic ds_rise_unused, oe_rise_unused;

  hc595_rx_monitor_sync_edge_det #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_ds (
    .clk(sys_clk), .rst(sys_rst), .d(ds), .q(ds_sync), .rise_c(ds_rise_unused));
  hc595_rx_monitor_sync_edge_det #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_shcp (
    .clk(sys_clk), .rst(sys_rst), .d(shcp), .q(shcp_sync), .rise_c(shcp_rise_c));
  hc595_rx_monitor_sync_edge_det #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_stcp (
    .clk(sys_clk), .rst(sys_rst), .d(stcp), .q(stcp_sync), .rise_c(stcp_rise_c));
  hc595_rx_monitor_sync_edge_det #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_oe (
    .clk(sys_clk), .rst(sys_rst), .d(oe), .q(oe_sync), .rise_c(oe_rise_unused));

  // oe_sync is already a flop output, so blank carries no delay beyond the synchroniser.
  assign blank = oe_sync;

  rx_state_e             state, state_nxt;
  logic [FRAME_BITS-1:0] sr, sr_nxt, sr_shift_c;
  logic [CNT_W-1:0]      cnt_nxt, cnt_shift_c;
  logic [SEG_W-1:0]      seg_nxt;
  logic [SEL_W-1:0]      sel_nxt;
  logic                  vld_nxt, err_nxt;
  frame_word_t           word_c;

  // State and output registers.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state     <= ST_IDLE;
      sr        <= '0;
      shift_cnt <= '0;
      seg_out   <= '0;
      sel_out   <= '0;
      frame_vld <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      sr        <= sr_nxt;
      shift_cnt <= cnt_nxt;
      seg_out   <= seg_nxt;
      sel_out   <= sel_nxt;
      frame_vld <= vld_nxt;
      frame_err <= err_nxt;
    end
  end

  // Shift first, then latch, so a coincident shift lands in the latched word and count.
  always_comb begin
    state_nxt   = state;
    sr_shift_c  = sr;
    cnt_shift_c = shift_cnt;
    seg_nxt     = seg_out;
    sel_nxt     = sel_out;
    vld_nxt     = 1'b0;
    err_nxt     = 1'b0;

    if (shcp_rise_c) begin
      sr_shift_c  = {sr[FRAME_BITS-2:0], ds_sync};
      cnt_shift_c = (shift_cnt == CNT_W'(CNT_MAX)) ? shift_cnt : shift_cnt + CNT_W'(1);
      if (state == ST_IDLE) begin
        state_nxt = ST_SHIFTING;
      end
    end

    word_c  = unpack_frame(sr_shift_c);
    sr_nxt  = sr_shift_c;
    cnt_nxt = cnt_shift_c;

    if (stcp_rise_c) begin
      seg_nxt   = word_c.seg;
      sel_nxt   = word_c.sel;
      vld_nxt   = (cnt_shift_c == CNT_W'(FRAME_BITS));
      err_nxt   = (cnt_shift_c != CNT_W'(FRAME_BITS));
      cnt_nxt   = '0;
      state_nxt = ST_IDLE;
    end
  end

endmodule
